// File: rtl/filter_peak_sequencer.sv
// Pulse peak sequencer: settle, arm, track peak, commit event, hold off.
// Ports: clk, reset (sync, active-low), enable, filt_data, threshold,
//   out_ready in; evt_valid/evt_amp/evt_time record, drop_cnt,
//   pileup_cnt (saturating), state_o out.
module filter_peak_sequencer #(
  parameter int          DW        = 16,
  parameter int          SETTLE    = 24,
  parameter int          MAX_WIDTH = 64,
  parameter int          HOLDOFF   = 16,
  // timestamp reset value; nonzero only to exercise wraparound
  parameter logic [31:0] TS_INIT   = 32'h0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [DW-1:0] filt_data,
  input  logic [DW-1:0] threshold,
  input  logic          out_ready,
  output logic          evt_valid,
  output logic [DW-1:0] evt_amp,
  output logic [31:0]   evt_time,
  output logic [15:0]   drop_cnt,
  output logic [15:0]   pileup_cnt,
  output logic [2:0]    state_o
);

  localparam int CMAX = (SETTLE > HOLDOFF) ? SETTLE : HOLDOFF;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int WW   = $clog2(MAX_WIDTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ARMED  = 3'd2,
    ST_PULSE  = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [WW-1:0]   r_width;
  logic [DW-1:0]   r_max;
  logic [31:0]     r_t0;
  logic [31:0]     r_ts;
  logic            r_valid;
  logic [DW-1:0]   r_amp;
  logic [31:0]     r_time;
  logic [15:0]     r_drop;
  logic [15:0]     r_pile;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [WW-1:0]   w_width_nxt;
  logic [DW-1:0]   w_max_nxt;
  logic [31:0]     w_t0_nxt;
  logic            w_commit;
  logic            w_pile;
  logic            w_above;

  always_comb begin
    w_above     = filt_data > threshold;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_width_nxt = r_width;
    w_max_nxt   = r_max;
    w_t0_nxt    = r_t0;
    w_commit    = 1'b0;
    w_pile      = 1'b0;
    if (!enable) begin
      // abort: no commit, no counter change
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = '0;
        end
        ST_SETTLE: begin
          if (r_cnt == CW'(SETTLE - 1)) begin
            w_state_nxt = ST_ARMED;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_ARMED: begin
          if (w_above) begin
            w_state_nxt = ST_PULSE;
            w_max_nxt   = filt_data;
            w_t0_nxt    = r_ts;
            w_width_nxt = WW'(1);
          end
        end
        ST_PULSE: begin
          if (!w_above) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
          end else begin
            if (filt_data > r_max) w_max_nxt = filt_data;
            // this sample would bring the width to MAX_WIDTH
            if (r_width == WW'(MAX_WIDTH - 1)) begin
              w_pile      = 1'b1;
              w_state_nxt = ST_HOLD;
              w_cnt_nxt   = '0;
            end else begin
              w_width_nxt = r_width + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // dead time restarts while the input is still over threshold
          if (w_above) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == CW'(HOLDOFF - 1)) begin
            w_state_nxt = ST_ARMED;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_width <= '0;
      r_max   <= '0;
      r_t0    <= '0;
      r_ts    <= TS_INIT;
      r_valid <= 1'b0;
      r_amp   <= '0;
      r_time  <= '0;
      r_drop  <= '0;
      r_pile  <= '0;
    end else begin
      r_ts    <= r_ts + 32'd1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_width <= w_width_nxt;
      r_max   <= w_max_nxt;
      r_t0    <= w_t0_nxt;
      if (w_commit) begin
        // ending sample is below threshold, so r_max is final
        if (!r_valid || out_ready) begin
          r_valid <= 1'b1;
          r_amp   <= r_max;
          r_time  <= r_t0;
        end else if (r_drop != 16'hFFFF) begin
          r_drop <= r_drop + 16'd1;
        end
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_pile && r_pile != 16'hFFFF) r_pile <= r_pile + 16'd1;
    end
  end

  assign evt_valid  = r_valid;
  assign evt_amp    = r_amp;
  assign evt_time   = r_time;
  assign drop_cnt   = r_drop;
  assign pileup_cnt = r_pile;
  assign state_o    = r_state;

endmodule

// File: tb/tb_filter_peak_sequencer.sv
// Directed bench for filter_peak_sequencer.
// Second instance starts its timestamp just below wrap.
module tb_filter_peak_sequencer;

  localparam logic [31:0] WRAP0 = 32'hFFFF_FFE6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] fd = '0;
  logic [15:0] thr = 16'd100;
  logic        out_ready = 1'b1;

  logic        valid;
  logic [15:0] amp;
  logic [31:0] etime;
  logic [15:0] drop;
  logic [15:0] pile;
  logic [2:0]  st;

  logic        w2_valid;
  logic [15:0] w2_amp;
  logic [31:0] w2_time;
  logic [15:0] w2_drop;
  logic [15:0] w2_pile;
  logic [2:0]  w2_st;

  logic [31:0] ts_m;
  int          n_cmp = 0;
  int          n_bad = 0;

  filter_peak_sequencer u_dut (
    .clk(clk), .reset(reset), .enable(enable),
    .filt_data(fd), .threshold(thr), .out_ready(out_ready),
    .evt_valid(valid), .evt_amp(amp), .evt_time(etime),
    .drop_cnt(drop), .pileup_cnt(pile), .state_o(st)
  );

  filter_peak_sequencer #(.TS_INIT(WRAP0)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable),
    .filt_data(fd), .threshold(thr), .out_ready(out_ready),
    .evt_valid(w2_valid), .evt_amp(w2_amp), .evt_time(w2_time),
    .drop_cnt(w2_drop), .pileup_cnt(w2_pile), .state_o(w2_st)
  );

  always #5 clk = ~clk;

  // reference timestamp: cleared by reset, +1 per edge
  always @(posedge clk) begin
    if (!reset) ts_m <= '0;
    else        ts_m <= ts_m + 32'd1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n = 0;
    while (st != s && n < 64) begin
      tick();
      n++;
    end
    chk(tag, 32'(st), 32'(s));
  endtask

  task automatic count_state(input logic [2:0] s, output int n);
    n = 0;
    while (st == s && n < 200) begin
      tick();
      n++;
    end
  endtask

  // precondition: ARMED; returns with the commit edge just taken
  task automatic pulse(input logic [15:0] a,
                       input logic [15:0] b,
                       input logic rdy_end,
                       output logic [31:0] t0);
    fd = a;
    t0 = ts_m;
    tick();
    fd = b;
    tick();
    fd = 16'd0;
    out_ready = rdy_end;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [31:0] t;
    logic [31:0] ta;
    logic [31:0] tb_;
    logic [31:0] tc;
    logic [31:0] tw;

    tick();
    tick();
    chk("rst_state", 32'(st), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_amp", 32'(amp), 32'd0);
    chk("rst_time", etime, 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    chk("rst_pile", 32'(pile), 32'd0);

    reset = 1'b1;
    enable = 1'b1;
    tick();
    chk("settle_entry", 32'(st), 32'd1);
    count_state(3'd1, n);
    chk("settle_len", 32'(n), 32'd24);
    chk("armed", 32'(st), 32'd2);
    chk("settle_no_evt", 32'(valid), 32'd0);

    fd = 16'd100;
    tick();
    chk("eq_thr_no_trig", 32'(st), 32'd2);
    thr = 16'd350;
    fd = 16'd300;
    tick();
    chk("thr_raised", 32'(st), 32'd2);
    thr = 16'd100;
    fd = 16'd50;
    tick();
    chk("below_armed", 32'(st), 32'd2);
    fd = 16'd150;
    t = ts_m;
    tick();
    chk("pulse_state", 32'(st), 32'd3);
    fd = 16'd300;
    tick();
    fd = 16'd200;
    tick();
    fd = 16'd90;
    tick();
    chk("end_hold", 32'(st), 32'd4);
    chk("evt_valid", 32'(valid), 32'd1);
    chk("evt_amp", 32'(amp), 32'd300);
    chk("evt_time", etime, t);
    fd = 16'd0;
    count_state(3'd4, n);
    chk("hold_len", 32'(n), 32'd16);
    chk("rearm", 32'(st), 32'd2);
    chk("evt_cleared", 32'(valid), 32'd0);

    fd = 16'd500;
    repeat (70) tick();
    chk("pile_cnt", 32'(pile), 32'd1);
    chk("pile_no_evt", 32'(valid), 32'd0);
    chk("pile_hold", 32'(st), 32'd4);
    fd = 16'd0;
    count_state(3'd4, n);
    chk("pile_hold_len", 32'(n), 32'd16);
    chk("pile_rearm", 32'(st), 32'd2);

    out_ready = 1'b0;
    pulse(16'd200, 16'd250, 1'b0, ta);
    chk("a_valid", 32'(valid), 32'd1);
    chk("a_amp", 32'(amp), 32'd250);
    wait_state(3'd2, "a_rearm");
    pulse(16'd400, 16'd180, 1'b0, tb_);
    chk("b_drop", 32'(drop), 32'd1);
    chk("b_held_amp", 32'(amp), 32'd250);
    chk("b_held_time", etime, ta);
    chk("b_held_valid", 32'(valid), 32'd1);
    wait_state(3'd2, "b_rearm");
    pulse(16'd120, 16'd130, 1'b1, tc);
    chk("c_valid", 32'(valid), 32'd1);
    chk("c_amp", 32'(amp), 32'd130);
    chk("c_time", etime, tc);
    chk("c_drop", 32'(drop), 32'd1);
    tick();
    chk("c_cleared", 32'(valid), 32'd0);

    wait_state(3'd2, "c_rearm");
    fd = 16'd300;
    tick();
    chk("abort_pulse", 32'(st), 32'd3);
    enable = 1'b0;
    fd = 16'd400;
    tick();
    chk("abort_idle", 32'(st), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_amp", 32'(amp), 32'd130);
    chk("abort_drop", 32'(drop), 32'd1);
    chk("abort_pile", 32'(pile), 32'd1);
    tick();
    chk("idle_stay", 32'(st), 32'd0);
    enable = 1'b1;
    fd = 16'd0;
    tick();
    count_state(3'd1, n);
    chk("resettle_len", 32'(n), 32'd24);

    fd = 16'd300;
    tick();
    chk("rst_pulse", 32'(st), 32'd3);
    reset = 1'b0;
    tick();
    chk("rst2_state", 32'(st), 32'd0);
    chk("rst2_drop", 32'(drop), 32'd0);
    chk("rst2_pile", 32'(pile), 32'd0);
    chk("rst2_amp", 32'(amp), 32'd0);
    reset = 1'b1;
    fd = 16'd0;
    tick();
    wait_state(3'd2, "wrap_armed");
    pulse(16'd400, 16'd350, 1'b1, tw);
    chk("wrap_amp", 32'(w2_amp), 32'd400);
    chk("wrap_time", w2_time, WRAP0 + tw);
    chk("wrap_prewrap", w2_time, 32'hFFFF_FFFF);
    chk("main_time", etime, tw);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
